videocard_pll_reset_seq: RTL
============================

// Module: videocard_pll_reset_seq
// PURPOSE
//  Sequences bring-up and recovery of the videocard PLL (50 MHz ref -> 50 MHz / 5 MHz outclks).
//  - Drives the PLL reset and qualifies its lock output.
//  - Releases the videocard system reset only after lock has been stable for a set time.
//  - Retries on lock timeout, latches a failure after too many retries, and re-runs on loss of lock.
//  - Runs on the free-running 50 MHz reference clock, never on a PLL output.
// PARAMETERS
//  RST_PULSE_CYCLES    16     cycles pll_rst is held high per PLL reset attempt (>=1)
//  LOCK_STABLE_CYCLES  1024   consecutive synced-lock cycles required before release (>=1)
//  LOCK_TIMEOUT_CYCLES 65536  max cycles in WAIT_LOCK+STABLE per attempt before retry (>=1)
//  MAX_RETRIES         3      failed attempts tolerated; the next failure enters FAIL (>=1)
// PORTS
//  clk            in   1  free-running 50 MHz reference clock (same net as PLL refclk)
//  reset_n        in   1  synchronous, active-low reset
//  locked         in   1  PLL locked, asynchronous to clk
//  restart        in   1  single-cycle soft request to restart the sequence
//  pll_rst        out  1  to PLL rst, active high
//  sys_rst_n      out  1  videocard logic reset, active low; registered, clk domain
//  ready          out  1  high only in RUN
//  fail           out  1  high only in FAIL
//  retry_cnt      out  2  failed attempts in the current sequence
//  lock_loss_cnt  out  8  lock losses seen in RUN; saturates at 255
// BEHAVIOUR
//  Reset and input sync
//  - While reset_n=0: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fail=0,
//    retry_cnt=0, lock_loss_cnt=0, and all counters cleared.
//  - locked passes through a 2-flop synchronizer; locked_s is the synchronized copy.
//    The synchronizer is cleared by reset. Only locked_s is used below.
//  States
//  - RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
//    pll_rst=0 from the first WAIT_LOCK cycle.
//  - WAIT_LOCK: the timeout counter runs.
//    - locked_s=1 -> STABLE, with the stable counter cleared.
//  - STABLE: stable counter +1 per cycle while locked_s=1; timeout counter keeps running.
//    - locked_s=0 -> back to WAIT_LOCK. Timeout is not restarted.
//    - Stable count reaches LOCK_STABLE_CYCLES -> RUN.
//  - Timeout: if the timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE:
//    - retry_cnt == MAX_RETRIES-1 -> FAIL, with retry_cnt incremented.
//    - otherwise -> RESET_PLL, with retry_cnt+1.
//  - RUN: sys_rst_n=1, ready=1, retry_cnt cleared.
//    - locked_s=0 -> RESET_PLL; lock_loss_cnt+1 (saturating); sys_rst_n=0 from the next cycle.
//  - FAIL: pll_rst=1, sys_rst_n=0, fail=1. Left only via reset_n or restart.
//  Outputs
//  - All outputs are registered and decoded from the state.
//  - sys_rst_n=0 in every state except RUN.
//  Latency
//  - Ideal bring-up: locked goes high at edge E, once pll_rst=0, and stays high.
//    sys_rst_n first reads 1 at edge E+LOCK_STABLE_CYCLES+3.
//  restart
//  - In any state (reset_n=1): next state=RESET_PLL; retry_cnt=0 and fail=0; the pulse count restarts.
//  - restart coinciding with a RUN lock loss: restart wins and lock_loss_cnt is not incremented.
//  - restart during RESET_PLL restarts the pulse count.
//  - lock_loss_cnt is never cleared by restart.
//  Boundary conditions
//  - Lock glitches shorter than the synchronizer window may be missed. This is acceptable.
//  - A timeout in the same cycle the stable count completes: RUN wins.
//  - Counter widths are $clog2(param+1). Counters never wrap.
//  - reset_n=0 mid-sequence aborts immediately to the reset values.
// TESTING (bench params: RST_PULSE=4, LOCK_STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
//  1 Release reset_n, raise locked 10 cycles after pll_rst falls, hold high
//    -> pll_rst high exactly 4 cycles; sys_rst_n=1 and ready=1 exactly 11 edges after locked rises.
//  2 Keep locked=0 forever
//    -> two 4-cycle pll_rst pulses, each 32 cycles apart in WAIT_LOCK;
//       then fail=1, retry_cnt=2, pll_rst=1, sys_rst_n stays 0.
//  3 In RUN, drop locked for 5 cycles
//    -> sys_rst_n=0 within 4 cycles; lock_loss_cnt=1; new 4-cycle pll_rst pulse; relock re-enters RUN.
//  4 In STABLE, drop locked at stable count 5
//    -> back to WAIT_LOCK; the full 8-cycle stable count is required again; timeout is not reset.
//  5 In FAIL, pulse restart
//    -> fail=0, retry_cnt=0, pll_rst pulse of 4 cycles, normal bring-up.
//    Restart coinciding with a lock loss -> lock_loss_cnt unchanged.
//  6 Force 260 lock losses in RUN -> lock_loss_cnt saturates at 255.
//    Assert reset_n=0 mid-STABLE -> all outputs take their reset values at the next edge.

Source files
------------

// File: rtl/videocard_pll_reset_seq.sv
// videocard_pll_reset_seq: PLL reset/lock sequencer that gates the videocard system reset
module videocard_pll_reset_seq #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [1:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, sys_rst_n_q, ready_q, fail_q;
  logic          locked_s, timeout, stable_done;
  assign locked_s    = sync_q[1];
  assign timeout     = timeout_q == TW'(LOCK_TIMEOUT_CYCLES - 1);
  assign stable_done = locked_s && stable_q == SW'(LOCK_STABLE_CYCLES - 1);
  always_comb begin
    state_d   = state_q;
    pulse_d   = '0;
    stable_d  = '0;
    timeout_d = '0;
    retry_d   = retry_q;
    loss_d    = loss_q;
    case (state_q)
      RESET_PLL: begin
        pulse_d = pulse_q + 1'b1;
        state_d = (pulse_q == PW'(RST_PULSE_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
      end
      WAIT_LOCK, STABLE: begin
        timeout_d = timeout_q + 1'b1;
        // completing the stable count beats a simultaneous timeout
        if (state_q == STABLE && stable_done) state_d = RUN;
        else if (timeout) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == 2'(MAX_RETRIES - 1)) ? FAIL : RESET_PLL;
        end else if (!locked_s) state_d = WAIT_LOCK;
        else begin
          state_d  = STABLE;
          stable_d = (state_q == STABLE) ? stable_q + 1'b1 : '0;
        end
      end
      RUN: begin
        state_d = locked_s ? RUN : RESET_PLL;
        loss_d  = (!locked_s && loss_q != 8'hff) ? loss_q + 1'b1 : loss_q;
      end
      FAIL: state_d = FAIL;
      default: state_d = RESET_PLL;
    endcase
    if (state_d == RUN) retry_d = '0;
    if (restart) begin
      state_d   = RESET_PLL;
      pulse_d   = '0;
      stable_d  = '0;
      timeout_d = '0;
      retry_d   = '0;
      loss_d    = loss_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      sync_q      <= '0;
      pulse_q     <= '0;
      stable_q    <= '0;
      timeout_q   <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], locked};
      pulse_q     <= pulse_d;
      stable_q    <= stable_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= state_d == RESET_PLL || state_d == FAIL;
      sys_rst_n_q <= state_d == RUN;
      ready_q     <= state_d == RUN;
      fail_q      <= state_d == FAIL;
    end
  end
  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
endmodule
